// File: rtl/smem_mem_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : smem_mem_write_arbiter_if
// Description : Bus bundle between the SMEM pipeline lanes, the MEM-queue
//               write port and the mem-size report port.
//               master : lane / MEM-queue side (drives lane requests,
//                        observes grants, writes and size reports)
//               slave  : arbiter side (consumes lane requests, drives
//                        lane_ready, the write port and the size report)
//               Lane i occupies bits [i*W +: W] of the packed lane vectors.
// Revision    : 1.0 - initial release
// ============================================================================
interface smem_mem_write_arbiter_if #(
    parameter int NUM_LANES      = 4,
    parameter int READ_NUM_WIDTH = 6,
    parameter int DATA_W         = 256
);
    logic [NUM_LANES-1:0]                lane_valid;
    logic [NUM_LANES-1:0]                lane_done;
    logic [NUM_LANES*READ_NUM_WIDTH-1:0] lane_read_num;
    logic [NUM_LANES*DATA_W-1:0]         lane_data;
    logic [NUM_LANES-1:0]                lane_ready;

    logic                                mem_we_1;
    logic [READ_NUM_WIDTH-1:0]           mem_read_num_1;
    logic [6:0]                          mem_addr_1;
    logic [DATA_W-1:0]                   mem_data_1;

    logic                                mem_size_valid;
    logic [6:0]                          mem_size;
    logic [READ_NUM_WIDTH-1:0]           mem_size_read_num;

    modport master (
        output lane_valid, lane_done, lane_read_num, lane_data,
        input  lane_ready,
        input  mem_we_1, mem_read_num_1, mem_addr_1, mem_data_1,
        input  mem_size_valid, mem_size, mem_size_read_num
    );

    modport slave (
        input  lane_valid, lane_done, lane_read_num, lane_data,
        output lane_ready,
        output mem_we_1, mem_read_num_1, mem_addr_1, mem_data_1,
        output mem_size_valid, mem_size, mem_size_read_num
    );
endinterface
`default_nettype wire

// File: rtl/smem_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : smem_mem_write_arbiter
// Description : Round-robin arbiter sharing the single MEM-queue write port
//               and the mem-size report port among NUM_LANES SMEM lanes.
//               Keeps a slot counter per read so lanes never compute MEM
//               queue addresses, reports the final count when a read is
//               closed, and counts closed reads toward batch_size.
// Ports       : clk, reset (sync, active high), stall (blocks grants),
//               batch_size (reads expected), batch_done (sticky),
//               overflow_err (sticky, entry dropped on a full read),
//               bus (slave modport: lane requests, one-hot combinational
//               lane_ready, registered write port and size report).
// Revision    : 1.0 - initial release
// ============================================================================
module smem_mem_write_arbiter #(
    parameter int NUM_LANES      = 4,
    parameter int READ_NUM_WIDTH = 6,
    parameter int MAX_READ       = 64,
    parameter int READ_MAX_MEM   = 40,
    parameter int DATA_W         = 256
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    stall,
    input  wire logic [READ_NUM_WIDTH:0] batch_size,
    output logic                         batch_done,
    output logic                         overflow_err,
    smem_mem_write_arbiter_if.slave      bus
);
    localparam int c_lane_w = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [6:0] c_max_mem = 7'(READ_MAX_MEM);
    localparam logic [READ_NUM_WIDTH:0] c_done_sat = '1;

    logic [c_lane_w-1:0]       rr_ptr_q, rr_ptr_d;
    logic [6:0]                slot_cnt_q [MAX_READ];
    logic [6:0]                slot_cnt_d [MAX_READ];
    logic [READ_NUM_WIDTH:0]   done_cnt_q, done_cnt_d;
    logic                      batch_done_q, batch_done_d;
    logic                      overflow_q, overflow_d;
    logic                      mem_we_q, mem_we_d;
    logic [READ_NUM_WIDTH-1:0] mem_read_num_q, mem_read_num_d;
    logic [6:0]                mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]         mem_data_q, mem_data_d;
    logic                      size_valid_q, size_valid_d;
    logic [6:0]                size_q, size_d;
    logic [READ_NUM_WIDTH-1:0] size_rn_q, size_rn_d;

    logic                      w_found;
    logic [c_lane_w-1:0]       w_gnt_idx;
    logic                      w_hs;
    logic                      w_sel_done;
    logic [READ_NUM_WIDTH-1:0] w_sel_rn;
    logic [DATA_W-1:0]         w_sel_data;
    logic [6:0]                w_cnt;

    // First requesting lane at or after rr_ptr, wrapping modulo NUM_LANES.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!w_found &&
                bus.lane_valid[c_lane_w'((int'(rr_ptr_q) + k) % NUM_LANES)]) begin
                w_found   = 1'b1;
                w_gnt_idx = c_lane_w'((int'(rr_ptr_q) + k) % NUM_LANES);
            end
        end
    end

    // A grant is itself the handshake: only a valid lane can be granted.
    assign w_hs           = w_found & ~stall & ~reset;
    assign bus.lane_ready = w_hs ? (NUM_LANES'(1) << w_gnt_idx) : '0;

    assign w_sel_done = bus.lane_done[w_gnt_idx];
    assign w_sel_rn   = bus.lane_read_num[w_gnt_idx*READ_NUM_WIDTH +: READ_NUM_WIDTH];
    assign w_sel_data = bus.lane_data[w_gnt_idx*DATA_W +: DATA_W];
    assign w_cnt      = slot_cnt_q[w_sel_rn];

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        slot_cnt_d     = slot_cnt_q;
        done_cnt_d     = done_cnt_q;
        overflow_d     = overflow_q;
        mem_we_d       = 1'b0;
        mem_read_num_d = mem_read_num_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        size_valid_d   = 1'b0;
        size_d         = size_q;
        size_rn_d      = size_rn_q;
        // Compares the registered count, so the flag rises one cycle after
        // the count reaches batch_size.
        batch_done_d   = batch_done_q |
                         ((done_cnt_q == batch_size) && (batch_size != '0));

        if (w_hs) begin
            rr_ptr_d = (w_gnt_idx == c_lane_w'(NUM_LANES - 1)) ? '0
                                                               : w_gnt_idx + 1'b1;
            if (w_sel_done) begin
                size_valid_d         = 1'b1;
                size_d               = w_cnt;
                size_rn_d            = w_sel_rn;
                slot_cnt_d[w_sel_rn] = '0;
                if (done_cnt_q != c_done_sat) begin
                    done_cnt_d = done_cnt_q + 1'b1;
                end
            end else if (w_cnt < c_max_mem) begin
                mem_we_d             = 1'b1;
                mem_addr_d           = w_cnt;
                mem_read_num_d       = w_sel_rn;
                mem_data_d           = w_sel_data;
                slot_cnt_d[w_sel_rn] = w_cnt + 1'b1;
            end else begin
                // Read already full: drop the entry, keep the count at max.
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            done_cnt_q     <= '0;
            batch_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_read_num_q <= '0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            size_valid_q   <= 1'b0;
            size_q         <= '0;
            size_rn_q      <= '0;
            for (int i = 0; i < MAX_READ; i++) begin
                slot_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            done_cnt_q     <= done_cnt_d;
            batch_done_q   <= batch_done_d;
            overflow_q     <= overflow_d;
            mem_we_q       <= mem_we_d;
            mem_read_num_q <= mem_read_num_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            size_valid_q   <= size_valid_d;
            size_q         <= size_d;
            size_rn_q      <= size_rn_d;
            slot_cnt_q     <= slot_cnt_d;
        end
    end

    assign bus.mem_we_1          = mem_we_q;
    assign bus.mem_read_num_1    = mem_read_num_q;
    assign bus.mem_addr_1        = mem_addr_q;
    assign bus.mem_data_1        = mem_data_q;
    assign bus.mem_size_valid    = size_valid_q;
    assign bus.mem_size          = size_q;
    assign bus.mem_size_read_num = size_rn_q;
    assign batch_done            = batch_done_q;
    assign overflow_err          = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_smem_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_smem_mem_write_arbiter
// Description : Self-checking bench for smem_mem_write_arbiter. Per-lane
//               beat queues feed the DUT; a transaction-level model (round
//               robin by modulo search, per-read slot counts in an int
//               array) predicts grants, writes, size reports and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smem_mem_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 6;
    localparam int D   = 256;
    localparam int MAXM = 40;

    typedef struct {
        bit         done;
        bit [W-1:0] rn;
        bit [D-1:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic [W:0]   batch_size;
    logic         batch_done;
    logic         overflow_err;

    smem_mem_write_arbiter_if #(.NUM_LANES(N), .READ_NUM_WIDTH(W), .DATA_W(D)) bus ();

    smem_mem_write_arbiter #(
        .NUM_LANES(N), .READ_NUM_WIDTH(W), .MAX_READ(64),
        .READ_MAX_MEM(MAXM), .DATA_W(D)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .batch_size(batch_size),
        .batch_done(batch_done), .overflow_err(overflow_err), .bus(bus)
    );

    always #5 clk = ~clk;

    beat_t      lane_q [N][$];
    bit         rst_in;
    bit         stall_in;
    int         n_err;
    int         n_chk;

    // Reference model state
    int         m_rr;
    int         m_cnt [64];
    int         m_done;
    bit         m_ovf, m_bdone, m_we, m_sv;
    int         m_addr, m_rn, m_size, m_srn;
    bit [D-1:0] m_data;

    task automatic check_val(input string tag, input logic [D-1:0] got,
                             input logic [D-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rr = 0; m_done = 0; m_ovf = 0; m_bdone = 0;
        m_we = 0; m_sv = 0; m_addr = 0; m_rn = 0; m_size = 0; m_srn = 0;
        m_data = '0;
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    endtask

    task automatic drive();
        reset = rst_in;
        stall = stall_in;
        for (int l = 0; l < N; l++) begin
            if (lane_q[l].size() > 0) begin
                bus.lane_valid[l]           = 1'b1;
                bus.lane_done[l]            = lane_q[l][0].done;
                bus.lane_read_num[l*W +: W] = lane_q[l][0].rn;
                bus.lane_data[l*D +: D]     = lane_q[l][0].data;
            end else begin
                bus.lane_valid[l]           = 1'b0;
                bus.lane_done[l]            = 1'b0;
                bus.lane_read_num[l*W +: W] = '0;
                bus.lane_data[l*D +: D]     = '0;
            end
        end
    endtask

    task automatic push(input int lane, input bit done, input int rn);
        beat_t b;
        b.done = done;
        b.rn   = W'(rn);
        for (int i = 0; i < D / 32; i++) b.data[i*32 +: 32] = $urandom;
        lane_q[lane].push_back(b);
    endtask

    // One clock: drive at the falling edge, check just after it, then
    // advance the model across the coming rising edge.
    task automatic cycle();
        int         g;
        logic [N-1:0] exp_rdy;
        beat_t      b;
        @(negedge clk);
        drive();
        #1;
        g = -1;
        if (!rst_in && !stall_in) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && lane_q[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        check_val("lane_ready", bus.lane_ready, exp_rdy);
        check_val("mem_we_1", bus.mem_we_1, m_we);
        if (m_we) begin
            check_val("mem_addr_1", bus.mem_addr_1, m_addr);
            check_val("mem_read_num_1", bus.mem_read_num_1, m_rn);
            check_val("mem_data_1", bus.mem_data_1, m_data);
        end
        check_val("mem_size_valid", bus.mem_size_valid, m_sv);
        if (m_sv) begin
            check_val("mem_size", bus.mem_size, m_size);
            check_val("mem_size_read_num", bus.mem_size_read_num, m_srn);
        end
        check_val("batch_done", batch_done, m_bdone);
        check_val("overflow_err", overflow_err, m_ovf);

        if (rst_in) begin
            model_clear();
        end else begin
            if (m_done == int'(batch_size) && batch_size != 0) m_bdone = 1;
            m_we = 0;
            m_sv = 0;
            if (g >= 0) begin
                b    = lane_q[g].pop_front();
                m_rr = (g + 1) % N;
                if (b.done) begin
                    m_sv   = 1;
                    m_size = m_cnt[b.rn];
                    m_srn  = b.rn;
                    m_cnt[b.rn] = 0;
                    m_done = (m_done < 127) ? m_done + 1 : 127;
                end else if (m_cnt[b.rn] < MAXM) begin
                    m_we   = 1;
                    m_addr = m_cnt[b.rn];
                    m_rn   = b.rn;
                    m_data = b.data;
                    m_cnt[b.rn]++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    function automatic bit any_pending();
        for (int l = 0; l < N; l++) if (lane_q[l].size() > 0) return 1;
        return 0;
    endfunction

    task automatic run_idle(input int max_cycles);
        int c = 0;
        while (any_pending() && c < max_cycles) begin
            cycle();
            c++;
        end
        check_val("drain_within_budget", c < max_cycles, 1'b1);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst_in = 1;
        cycle();
        cycle();
        rst_in = 0;
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        rst_in = 1; stall_in = 0; batch_size = '0;
        model_clear();
        drive();
        do_reset();

        // Single lane: three entries to read 5 then close, then reuse.
        for (int i = 0; i < 3; i++) push(0, 0, 5);
        push(0, 1, 5);
        push(0, 0, 5);
        run_idle(50);

        // All lanes busy: strict rotation, independent per-read slots.
        for (int i = 0; i < 6; i++)
            for (int l = 0; l < N; l++) push(l, 0, 10 + l);
        for (int l = 0; l < N; l++) push(l, 1, 10 + l);
        run_idle(100);

        // Stall holds off lanes 1 and 2.
        stall_in = 1;
        push(1, 0, 20);
        push(2, 0, 21);
        repeat (5) cycle();
        stall_in = 0;
        run_idle(20);

        // Overflow: 41 entries to read 7, then close.
        for (int i = 0; i < MAXM + 1; i++) push(3, 0, 7);
        push(3, 1, 7);
        run_idle(100);
        check_val("overflow_sticky", overflow_err, 1'b1);

        // Batch completion with a zero-entry read.
        do_reset();
        batch_size = 7'd3;
        push(0, 0, 0); push(0, 0, 0); push(0, 1, 0);
        push(1, 1, 1);
        push(2, 0, 2); push(2, 1, 2);
        run_idle(50);
        check_val("batch_done_set", batch_done, 1'b1);

        // Reset while a beat is presented: it re-lands at slot 0.
        push(0, 0, 9); push(0, 0, 9);
        run_idle(20);
        push(0, 0, 9);
        rst_in = 1;
        cycle();
        rst_in = 0;
        run_idle(20);
        check_val("batch_done_cleared", batch_done, 1'b0);

        // Randomized traffic, including closes well past batch_size.
        do_reset();
        batch_size = 7'd10;
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < N; l++) begin
                if (lane_q[l].size() == 0 && $urandom_range(0, 2) == 0)
                    push(l, $urandom_range(0, 5) == 0, $urandom_range(0, 7));
            end
            stall_in = ($urandom_range(0, 7) == 0);
            cycle();
        end
        stall_in = 0;
        run_idle(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/smem_mem_write_arbiter.md
Name: smem_mem_write_arbiter

Overview:
- Shares the single MEM-queue write port (mem_we_1 / mem_read_num_1 / mem_addr_1 / mem_data_1) and the mem-size report port among NUM_LANES SMEM pipeline lanes.
- Round-robin arbitration; one beat accepted per cycle.
- Keeps a per-read slot counter, so lanes never compute MEM-queue addresses themselves.
- When a lane closes a read, reports that read's final MEM count and counts completed reads toward batch_size.

Parameters:
NUM_LANES, 4, number of requesting pipeline lanes
READ_NUM_WIDTH, 6, read-number width
MAX_READ, 64, reads per batch (counter-table depth)
READ_MAX_MEM, 40, MEM slots per read
DATA_W, 256, MEM entry width ([p_info, p_x2, p_x1, p_x0])

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  global pipeline stall; no grant while high
batch_size  in  READ_NUM_WIDTH+1  reads expected this batch
lane_valid  in  NUM_LANES  per-lane request
lane_done  in  NUM_LANES  qualifies lane_valid: 1 = close read (no data), 0 = MEM entry
lane_read_num  in  NUM_LANES*READ_NUM_WIDTH  read number per lane (lane i at [i*W +: W])
lane_data  in  NUM_LANES*DATA_W  MEM entry per lane
lane_ready  out  NUM_LANES  one-hot grant, combinational
mem_we_1  out  1  MEM-queue write strobe
mem_read_num_1  out  READ_NUM_WIDTH  write read number
mem_addr_1  out  7  slot index within the read
mem_data_1  out  DATA_W  write data
mem_size_valid  out  1  read-close pulse
mem_size  out  7  final MEM count of the closed read
mem_size_read_num  out  READ_NUM_WIDTH  closed read number
batch_done  out  1  sticky: done count reached batch_size
overflow_err  out  1  sticky: entry dropped because the read was full

Behaviour:
- Reset: all outputs 0, round-robin pointer = lane 0, all slot counters 0, done counter 0.
  - Reset mid-transfer discards any beat in flight; no write issues the cycle after reset.
- Arbitration:
  - When stall=0, grant the first lane with lane_valid=1, searching from rr_ptr upward (mod NUM_LANES).
  - lane_ready asserts for the granted lane only; it is 0 for every lane while stall=1.
  - Handshake = lane_valid & lane_ready. The lane holds its valid, done, read_num and data stable until accepted.
  - After a grant, rr_ptr = granted lane + 1 (wraps to 0). No grant leaves rr_ptr unchanged.
- Entry beat (lane_done=0), accepted with cnt = slot_cnt[read_num]:
  - If cnt < READ_MAX_MEM: next cycle mem_we_1=1, mem_addr_1=cnt, mem_read_num_1 and mem_data_1 registered from the lane; slot_cnt[read_num] <= cnt+1.
  - If cnt == READ_MAX_MEM: no write, counter unchanged, overflow_err <= 1.
- Done beat (lane_done=1):
  - Next cycle mem_size_valid=1, mem_size=slot_cnt[read_num] (after overflow, this is READ_MAX_MEM), mem_size_read_num=read_num.
  - slot_cnt[read_num] <= 0 and done_cnt <= done_cnt+1.
  - A read with zero entries reports mem_size=0.
- Latency: all write-port and size outputs are registered, exactly 1 cycle after the handshake. They are single-cycle pulses, and mem_we_1 and mem_size_valid are never both high.
- Back-to-back beats to the same read_num see the updated counter: consecutive slots 0,1,2 with no gaps or duplicates.
- batch_done <= 1 the cycle after done_cnt == batch_size with batch_size != 0. It holds until reset.
  - Done beats arriving after batch_done are still written and reported.
  - done_cnt saturates at 2^(READ_NUM_WIDTH+1)-1.
- Data fields pass through unmodified; no width truncation beyond the stated ports.

Test Plan:
- Single lane 0: 3 entries for read 5, then done -> writes (5,0),(5,1),(5,2) on consecutive cycles, then mem_size_valid with mem_size=3, read 5; slot_cnt[5] returns to 0.
- All 4 lanes valid continuously, stall=0 -> grants in order 0,1,2,3,0,…, one per cycle; each lane's slot addresses increment independently per its read_num.
- stall=1 for 5 cycles while lanes 1,2 are valid -> lane_ready=0 and mem_we_1=0 throughout; after release lane 1 is granted first, then lane 2.
- 41 entries to read 7, then done -> slots 0..39 written, 41st dropped, overflow_err=1, mem_size=40.
- batch_size=3, done beats for reads 0,1,2 (read 1 with zero entries) -> mem_size 0 reported for read 1; batch_done=1 the cycle after the third close, and 0 before it.
- Reset asserted the cycle a beat is accepted -> next cycle mem_we_1=0, all counters cleared; re-sent entry lands at slot 0.
